// File: rtl/ex_mdu_unit_if.sv
// EX-stage bus for ex_mdu_unit: issue signals from the decode side, EX/MEM
// results, HI/LO and the stall request back upstream.
interface ex_mdu_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8
);
    logic                  ex_valid;
    logic                  ex_flush;
    logic [OP_W-1:0]       ex_alu_op;
    logic [DATA_W-1:0]     ex_alu_src1;
    logic [DATA_W-1:0]     ex_alu_src2;
    logic                  ex_regfile_we;
    logic [REG_ADDR_W-1:0] ex_regfile_waddr;
    logic                  ex_stall_req;
    logic                  ex_mem_valid;
    logic [DATA_W-1:0]     ex_alu_result;
    logic                  ex_mem_regfile_we;
    logic [REG_ADDR_W-1:0] ex_mem_regfile_waddr;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic                  div_by_zero;

    modport master (
        output ex_valid, ex_flush, ex_alu_op, ex_alu_src1, ex_alu_src2,
               ex_regfile_we, ex_regfile_waddr,
        input  ex_stall_req, ex_mem_valid, ex_alu_result, ex_mem_regfile_we,
               ex_mem_regfile_waddr, hi, lo, div_by_zero
    );

    modport slave (
        input  ex_valid, ex_flush, ex_alu_op, ex_alu_src1, ex_alu_src2,
               ex_regfile_we, ex_regfile_waddr,
        output ex_stall_req, ex_mem_valid, ex_alu_result, ex_mem_regfile_we,
               ex_mem_regfile_waddr, hi, lo, div_by_zero
    );
endinterface

// File: rtl/ex_mdu_unit.sv
// Execute stage: single-cycle logic/shift ALU plus iterative MUL/DIV with HI/LO.
// Define EX_MDU_EARLY_OUT_EN to let MUL stop once the remaining multiplier bits are zero.
module ex_mdu_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    ex_mdu_unit_if.slave  bus
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] EXE_AND_OP   = OP_W'(8'h24);
    localparam logic [OP_W-1:0] EXE_OR_OP    = OP_W'(8'h25);
    localparam logic [OP_W-1:0] EXE_XOR_OP   = OP_W'(8'h26);
    localparam logic [OP_W-1:0] EXE_NOR_OP   = OP_W'(8'h27);
    localparam logic [OP_W-1:0] EXE_SLL_OP   = OP_W'(8'h7C);
    localparam logic [OP_W-1:0] EXE_SRL_OP   = OP_W'(8'h02);
    localparam logic [OP_W-1:0] EXE_SRA_OP   = OP_W'(8'h03);
    localparam logic [OP_W-1:0] EXE_MFHI_OP  = OP_W'(8'h10);
    localparam logic [OP_W-1:0] EXE_MTHI_OP  = OP_W'(8'h11);
    localparam logic [OP_W-1:0] EXE_MFLO_OP  = OP_W'(8'h12);
    localparam logic [OP_W-1:0] EXE_MTLO_OP  = OP_W'(8'h13);
    localparam logic [OP_W-1:0] EXE_MULT_OP  = OP_W'(8'h18);
    localparam logic [OP_W-1:0] EXE_MULTU_OP = OP_W'(8'h19);
    localparam logic [OP_W-1:0] EXE_DIV_OP   = OP_W'(8'h1A);
    localparam logic [OP_W-1:0] EXE_DIVU_OP  = OP_W'(8'h1B);

`ifdef EX_MDU_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t                state;
    logic [SH_W-1:0]       cnt;
    logic [2*DATA_W-1:0]   mcand, prod;
    logic [DATA_W-1:0]     mplier, dvs, quo, rem;
    logic                  res_neg, rem_neg;
    logic [DATA_W-1:0]     hi_q, lo_q, result_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic                  valid_q, we_q, dbz_q;

    logic [DATA_W-1:0]     src1, src2, mag1, mag2, alu_res;
    logic [SH_W-1:0]       sh;
    logic                  is_mul, is_div, is_signed, is_mthi, is_mtlo, alu_we;
    logic                  src1_neg, src2_neg, mul_last, div_last;
    logic [2*DATA_W-1:0]   prod_next;
    logic [DATA_W:0]       rem_shift, diff;
    logic [DATA_W-1:0]     rem_next, quo_next;

    assign src1 = bus.ex_alu_src1;
    assign src2 = bus.ex_alu_src2;
    assign sh   = src1[SH_W-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    always_comb begin
        alu_res   = '0;
        alu_we    = bus.ex_regfile_we;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        case (bus.ex_alu_op)
            EXE_AND_OP:   alu_res = src1 & src2;
            EXE_OR_OP:    alu_res = src1 | src2;
            EXE_XOR_OP:   alu_res = src1 ^ src2;
            EXE_NOR_OP:   alu_res = ~(src1 | src2);
            EXE_SLL_OP:   alu_res = src2 << sh;
            EXE_SRL_OP:   alu_res = src2 >> sh;
            EXE_SRA_OP:   alu_res = DATA_W'($signed(src2) >>> sh);
            EXE_MFHI_OP:  alu_res = hi_q;
            EXE_MFLO_OP:  alu_res = lo_q;
            EXE_MTHI_OP:  begin alu_res = src1; alu_we = 1'b0; is_mthi = 1'b1; end
            EXE_MTLO_OP:  begin alu_res = src1; alu_we = 1'b0; is_mtlo = 1'b1; end
            EXE_MULT_OP:  begin is_mul = 1'b1; is_signed = 1'b1; end
            EXE_MULTU_OP: is_mul = 1'b1;
            EXE_DIV_OP:   begin is_div = 1'b1; is_signed = 1'b1; end
            EXE_DIVU_OP:  is_div = 1'b1;
            default:      alu_we = 1'b0;
        endcase
    end

    assign src1_neg = is_signed & src1[DATA_W-1];
    assign src2_neg = is_signed & src2[DATA_W-1];
    assign mag1     = src1_neg ? -src1 : src1;
    assign mag2     = src2_neg ? -src2 : src2;

    // One shift-add step and one restoring-division step per cycle.
    assign prod_next = prod + (mplier[0] ? mcand : '0);
    assign rem_shift = {rem, quo[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, dvs};
    assign rem_next  = diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_next  = {quo[DATA_W-2:0], ~diff[DATA_W]};
    assign div_last  = (cnt == SH_W'(DATA_W - 1));
    assign mul_last  = div_last || (EARLY_OUT && (mplier[DATA_W-1:1] == '0));

    assign bus.ex_stall_req = !bus.ex_flush &&
                              ((state != IDLE) || (bus.ex_valid && (is_mul || is_div)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            mplier   <= '0;
            dvs      <= '0;
            quo      <= '0;
            rem      <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            if (bus.ex_flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.ex_valid) begin
                        cnt     <= '0;
                        res_neg <= src1_neg ^ src2_neg;
                        rem_neg <= src1_neg;
                        if (is_mul) begin
                            mcand  <= {{DATA_W{1'b0}}, mag1};
                            mplier <= mag2;
                            prod   <= '0;
                            state  <= MUL;
                        end else if (is_div && (src2 == '0)) begin
                            hi_q     <= src1;
                            lo_q     <= '1;
                            dbz_q    <= 1'b1;
                            valid_q  <= 1'b1;
                            result_q <= '0;
                            we_q     <= 1'b0;
                            waddr_q  <= '0;
                        end else if (is_div) begin
                            dvs   <= mag2;
                            quo   <= mag1;
                            rem   <= '0;
                            state <= DIV;
                        end else begin
                            valid_q  <= 1'b1;
                            result_q <= alu_res;
                            we_q     <= alu_we;
                            waddr_q  <= bus.ex_regfile_waddr;
                            if (is_mthi) hi_q <= src1;
                            if (is_mtlo) lo_q <= src1;
                        end
                    end
                    MUL: begin
                        prod   <= prod_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (mul_last) begin
                            {hi_q, lo_q} <= res_neg ? -prod_next : prod_next;
                            state    <= IDLE;
                            cnt      <= '0;
                            valid_q  <= 1'b1;
                            result_q <= '0;
                            we_q     <= 1'b0;
                            waddr_q  <= '0;
                        end
                    end
                    DIV: begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                        if (div_last) begin
                            lo_q     <= res_neg ? -quo_next : quo_next;
                            hi_q     <= rem_neg ? -rem_next : rem_next;
                            state    <= IDLE;
                            cnt      <= '0;
                            valid_q  <= 1'b1;
                            result_q <= '0;
                            we_q     <= 1'b0;
                            waddr_q  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ex_mem_valid         = valid_q;
    assign bus.ex_alu_result        = result_q;
    assign bus.ex_mem_regfile_we    = we_q;
    assign bus.ex_mem_regfile_waddr = waddr_q;
    assign bus.hi                   = hi_q;
    assign bus.lo                   = lo_q;
    assign bus.div_by_zero          = dbz_q;
endmodule

// File: tb/tb_ex_mdu_unit.sv
// Directed bench for ex_mdu_unit at DATA_W=32: ALU ops, MUL/DIV, divide by zero,
// flush and reset aborts; stall lengths follow EX_MDU_EARLY_OUT_EN when defined.
module tb_ex_mdu_unit;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

`ifdef EX_MDU_EARLY_OUT_EN
    localparam int STALL_BY_1  = 2;
    localparam int STALL_BY_0  = 2;
    localparam int STALL_BY_16 = 6;
`else
    localparam int STALL_BY_1  = 33;
    localparam int STALL_BY_0  = 33;
    localparam int STALL_BY_16 = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc, busy_valid;

    always #5 clk = ~clk;

    ex_mdu_unit_if #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(8)) bus_if ();

    ex_mdu_unit #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic we, input logic [4:0] waddr);
        bus_if.ex_valid         = 1'b1;
        bus_if.ex_alu_op        = op;
        bus_if.ex_alu_src1      = a;
        bus_if.ex_alu_src2      = b;
        bus_if.ex_regfile_we    = we;
        bus_if.ex_regfile_waddr = waddr;
        #1;
    endtask

    task automatic alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        present(op, a, b, 1'b1, 5'd7);
        step();
        bus_if.ex_valid = 1'b0;
    endtask

    // Presents an MDU op, drops ex_valid after the accept edge and counts stall cycles.
    task automatic run_mdu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int n, output int bv);
        present(op, a, b, 1'b0, 5'd0);
        n  = 0;
        bv = 0;
        while (bus_if.ex_stall_req && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            bus_if.ex_valid = 1'b0;
            #1;
            if (bus_if.ex_stall_req && bus_if.ex_mem_valid) bv++;
        end
    endtask

    initial begin
        bus_if.ex_valid         = 1'b0;
        bus_if.ex_flush         = 1'b0;
        bus_if.ex_alu_op        = '0;
        bus_if.ex_alu_src1      = '0;
        bus_if.ex_alu_src2      = '0;
        bus_if.ex_regfile_we    = 1'b0;
        bus_if.ex_regfile_waddr = '0;
        step();
        step();
        check("rst_valid", bus_if.ex_mem_valid, 0);
        check("rst_result", bus_if.ex_alu_result, 0);
        check("rst_we", bus_if.ex_mem_regfile_we, 0);
        check("rst_waddr", bus_if.ex_mem_regfile_waddr, 0);
        check("rst_hi", bus_if.hi, 0);
        check("rst_lo", bus_if.lo, 0);
        check("rst_stall", bus_if.ex_stall_req, 0);
        check("rst_dbz", bus_if.div_by_zero, 0);
        rst = 1'b0;
        step();

        present(OP_OR, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, 5'd3);
        check("or_stall", bus_if.ex_stall_req, 0);
        step();
        bus_if.ex_valid = 1'b0;
        check("or_result", bus_if.ex_alu_result, 32'h0F0F_00FF);
        check("or_we", bus_if.ex_mem_regfile_we, 1);
        check("or_waddr", bus_if.ex_mem_regfile_waddr, 3);
        check("or_valid", bus_if.ex_mem_valid, 1);
        step();
        check("idle_valid", bus_if.ex_mem_valid, 0);

        alu(OP_SRA, 32'd4, 32'h8000_0000);
        check("sra", bus_if.ex_alu_result, 32'hF800_0000);
        alu(OP_SRL, 32'd4, 32'h8000_0000);
        check("srl", bus_if.ex_alu_result, 32'h0800_0000);
        alu(OP_SLL, 32'h21, 32'h0000_0001);
        check("sll_amt_wrap", bus_if.ex_alu_result, 32'h0000_0002);
        alu(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("and", bus_if.ex_alu_result, 32'h0F00_0F00);
        alu(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("xor", bus_if.ex_alu_result, 32'hF00F_F00F);
        alu(OP_NOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check("nor", bus_if.ex_alu_result, 32'h00F0_00F0);
        alu(8'hEE, 32'h1234_5678, 32'h1);
        check("unk_valid", bus_if.ex_mem_valid, 1);
        check("unk_result", bus_if.ex_alu_result, 0);
        check("unk_we", bus_if.ex_mem_regfile_we, 0);

        alu(OP_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_result", bus_if.ex_alu_result, 32'h1234_5678);
        check("mthi_we", bus_if.ex_mem_regfile_we, 0);
        check("mthi_hi", bus_if.hi, 32'h1234_5678);
        alu(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        check("mtlo_lo", bus_if.lo, 32'h9ABC_DEF0);
        alu(OP_MFHI, 32'h0, 32'h0);
        check("mfhi_result", bus_if.ex_alu_result, 32'h1234_5678);
        check("mfhi_we", bus_if.ex_mem_regfile_we, 1);

        bus_if.ex_flush = 1'b1;
        present(OP_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd1);
        step();
        bus_if.ex_valid = 1'b0;
        bus_if.ex_flush = 1'b0;
        check("flushop_valid", bus_if.ex_mem_valid, 0);
        check("flushop_lo", bus_if.lo, 32'h9ABC_DEF0);

        run_mdu(OP_MULT, -32'sd3, 32'sd7, cyc, busy_valid);
        check("mult_stall", cyc, 33);
        check("mult_busy_valid", busy_valid, 0);
        check("mult_valid", bus_if.ex_mem_valid, 1);
        check("mult_we", bus_if.ex_mem_regfile_we, 0);
        check("mult_hilo", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        alu(OP_MFLO, 32'h0, 32'h0);
        check("mflo_after_mult", bus_if.ex_alu_result, 32'hFFFF_FFEB);

        run_mdu(OP_DIV, -32'sd7, 32'sd2, cyc, busy_valid);
        check("div_stall", cyc, 33);
        check("div_hilo", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_dbz", bus_if.div_by_zero, 0);

        run_mdu(OP_DIVU, 32'd7, 32'd0, cyc, busy_valid);
        check("dbz_stall", cyc, 1);
        check("dbz_hilo", {bus_if.hi, bus_if.lo}, 64'h0000_0007_FFFF_FFFF);
        check("dbz_pulse", bus_if.div_by_zero, 1);
        check("dbz_valid", bus_if.ex_mem_valid, 1);
        step();
        check("dbz_pulse_end", bus_if.div_by_zero, 0);

        run_mdu(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, busy_valid);
        check("div_min_m1", {bus_if.hi, bus_if.lo}, 64'h0000_0000_8000_0000);
        run_mdu(OP_DIV, 32'sd7, -32'sd2, cyc, busy_valid);
        check("div_pos_neg", {bus_if.hi, bus_if.lo}, 64'h0000_0001_FFFF_FFFD);
        run_mdu(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, busy_valid);
        check("multu_max", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFE_0000_0001);

        present(OP_DIVU, 32'd100, 32'd3, 1'b0, 5'd0);
        step();
        bus_if.ex_valid = 1'b0;
        repeat (10) step();
        check("flush_busy_stall", bus_if.ex_stall_req, 1);
        bus_if.ex_flush = 1'b1;
        #1;
        check("flush_stall_drop", bus_if.ex_stall_req, 0);
        step();
        bus_if.ex_flush = 1'b0;
        #1;
        check("flush_valid", bus_if.ex_mem_valid, 0);
        check("flush_idle_stall", bus_if.ex_stall_req, 0);
        repeat (30) step();
        check("flush_no_late", bus_if.ex_mem_valid, 0);
        check("flush_hilo", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFE_0000_0001);

        present(OP_MULT, 32'd3, 32'd5, 1'b0, 5'd0);
        step();
        bus_if.ex_valid = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("rstmul_hilo", {bus_if.hi, bus_if.lo}, 0);
        check("rstmul_stall", bus_if.ex_stall_req, 0);
        check("rstmul_valid", bus_if.ex_mem_valid, 0);
        step();
        rst = 1'b0;
        repeat (40) step();
        check("rstmul_no_late", {bus_if.hi, bus_if.lo}, 0);

        run_mdu(OP_MULTU, 32'd5, 32'd1, cyc, busy_valid);
        check("multu_x1_stall", cyc, STALL_BY_1);
        check("multu_x1", {bus_if.hi, bus_if.lo}, 64'd5);
        run_mdu(OP_MULTU, 32'd5, 32'd0, cyc, busy_valid);
        check("multu_x0_stall", cyc, STALL_BY_0);
        check("multu_x0", {bus_if.hi, bus_if.lo}, 64'd0);
        run_mdu(OP_MULTU, 32'd6, 32'h10, cyc, busy_valid);
        check("multu_x16_stall", cyc, STALL_BY_16);
        check("multu_x16", {bus_if.hi, bus_if.lo}, 64'h60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
